z80fi_block_xfer_spec: RTL and testbench

- Formal instruction-spec block for the Z80 block-transfer group: LDI, LDD, LDIR, LDDR.
- Combinational spec of one retirement: bus addresses, write data, HL/DE/BC/IP outputs, driven into the z80fi checker like every other insn spec.
- Adds a sequential repeat tracker that follows LDIR/LDDR across successive retirements, counts iterations and flags broken chains. This is behaviour a single-shot spec cannot express.

---
 rtl/z80fi_block_pkg.sv | 33 +++
 rtl/z80fi_block_xfer_spec_rep_tracker.sv | 159 +++++++++++++++
 rtl/z80fi_block_xfer_spec.sv | 111 +++++++++++
 tb/tb_z80fi_block_xfer_spec.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80fi_block_pkg.sv
// Shared constants and types for the Z80 block-transfer (LDI/LDD/LDIR/LDDR) instruction spec.
// The optional flag model is enabled by defining Z80FI_BLOCK_FLAGS_EN.
package z80fi_block_pkg;

    localparam logic [7:0] PREFIX_ED = 8'hED;
    localparam logic [7:0] OP_LDI    = 8'hA0;
    localparam logic [7:0] OP_LDD    = 8'hA8;
    localparam logic [7:0] OP_LDIR   = 8'hB0;
    localparam logic [7:0] OP_LDDR   = 8'hB8;

    localparam int DIR_BIT = 3;
    localparam int REP_BIT = 4;

    // Update-mask layout presented to the checker.
    localparam int SPEC_SIGNALS_W = 8;
    localparam int SIG_REG_IP = 0;
    localparam int SIG_REG_HL = 1;
    localparam int SIG_REG_DE = 2;
    localparam int SIG_REG_BC = 3;
    localparam int SIG_REG_F  = 4;
    localparam int SIG_MEM_RD = 5;
    localparam int SIG_MEM_WR = 6;

    typedef enum logic {
        ST_IDLE,
        ST_REPEAT
    } rep_state_t;

    function automatic logic is_block_op(input logic [7:0] op);
        return (op == OP_LDI) || (op == OP_LDD) || (op == OP_LDIR) || (op == OP_LDDR);
    endfunction

endpackage

// File: rtl/z80fi_block_xfer_spec_rep_tracker.sv
// Repeat-chain tracker: follows LDIR/LDDR across retirements, counts iterations, flags broken chains.
// With Z80FI_BLOCK_FLAGS_EN defined, the F register must also match on continuation.
module z80fi_rep_tracker
    import z80fi_block_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              z80fi_valid,
    input  logic              blk_valid,
    input  logic              is_rep,
    input  logic [7:0]        opcode,
    input  logic [ADDR_W-1:0] ip_in,
    input  logic [ADDR_W-1:0] hl_in,
    input  logic [ADDR_W-1:0] de_in,
    input  logic [ADDR_W-1:0] bc_in,
    input  logic [ADDR_W-1:0] ip_out,
    input  logic [ADDR_W-1:0] hl_out,
    input  logic [ADDR_W-1:0] de_out,
    input  logic [ADDR_W-1:0] bc_out,
`ifdef Z80FI_BLOCK_FLAGS_EN
    input  logic [7:0]        f_in,
    input  logic [7:0]        f_out,
`endif
    output logic              rep_active,
    output logic [CNT_W-1:0]  rep_count,
    output logic              rep_sat,
    output logic              rep_err,
    output logic              rep_abort
);

    localparam logic [CNT_W:0] MAX_ITER_W = (CNT_W+1)'(MAX_ITER);

    rep_state_t        state_q, state_d;
    logic [ADDR_W-1:0] exp_ip_q, exp_ip_d, exp_hl_q, exp_hl_d;
    logic [ADDR_W-1:0] exp_de_q, exp_de_d, exp_bc_q, exp_bc_d;
    logic [7:0]        exp_op_q, exp_op_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sat_q, sat_d, err_q, err_d, abort_q, abort_d;
    logic [CNT_W:0]    count_inc;
    logic              bc_nz, same_insn, regs_match;
`ifdef Z80FI_BLOCK_FLAGS_EN
    logic [7:0]        exp_f_q, exp_f_d;
`endif

    assign bc_nz      = (bc_out != '0);
    assign count_inc  = {1'b0, count_q} + (CNT_W+1)'(1);
    assign same_insn  = blk_valid && (opcode == exp_op_q) && (ip_in == exp_ip_q);
`ifdef Z80FI_BLOCK_FLAGS_EN
    assign regs_match = (hl_in == exp_hl_q) && (de_in == exp_de_q) && (bc_in == exp_bc_q)
                        && (f_in == exp_f_q);
`else
    assign regs_match = (hl_in == exp_hl_q) && (de_in == exp_de_q) && (bc_in == exp_bc_q);
`endif

    always_comb begin
        state_d  = state_q;
        exp_ip_d = exp_ip_q;
        exp_hl_d = exp_hl_q;
        exp_de_d = exp_de_q;
        exp_bc_d = exp_bc_q;
        exp_op_d = exp_op_q;
`ifdef Z80FI_BLOCK_FLAGS_EN
        exp_f_d  = exp_f_q;
`endif
        count_d  = count_q;
        sat_d    = sat_q;
        err_d    = 1'b0;
        abort_d  = 1'b0;

        // Expected fields are always this retirement's post-state, i.e. the next iteration's pre-state.
        if (blk_valid && (state_q == ST_REPEAT ? (same_insn && regs_match) : (is_rep && bc_nz))) begin
            exp_ip_d = ip_out;
            exp_hl_d = hl_out;
            exp_de_d = de_out;
            exp_bc_d = bc_out;
            exp_op_d = opcode;
`ifdef Z80FI_BLOCK_FLAGS_EN
            exp_f_d  = f_out;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (blk_valid && is_rep && bc_nz) begin
                    state_d = ST_REPEAT;
                    count_d = CNT_W'(1);
                    sat_d   = 1'b0;
                end
            end
            ST_REPEAT: begin
                if (z80fi_valid) begin
                    if (same_insn && regs_match) begin
                        count_d = count_inc[CNT_W] ? count_q : count_inc[CNT_W-1:0];
                        if (count_inc >= MAX_ITER_W) begin
                            sat_d = 1'b1;
                        end
                        if (!bc_nz) begin
                            state_d = ST_IDLE;
                            count_d = '0;
                        end
                    end else if (same_insn) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else begin
                        // Interrupts may legally break a chain; reported, not treated as an error.
                        abort_d = 1'b1;
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            exp_ip_q <= '0;
            exp_hl_q <= '0;
            exp_de_q <= '0;
            exp_bc_q <= '0;
            exp_op_q <= '0;
`ifdef Z80FI_BLOCK_FLAGS_EN
            exp_f_q  <= '0;
`endif
            count_q  <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_ip_q <= exp_ip_d;
            exp_hl_q <= exp_hl_d;
            exp_de_q <= exp_de_d;
            exp_bc_q <= exp_bc_d;
            exp_op_q <= exp_op_d;
`ifdef Z80FI_BLOCK_FLAGS_EN
            exp_f_q  <= exp_f_d;
`endif
            count_q  <= count_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
        end
    end

    assign rep_active = (state_q == ST_REPEAT);
    assign rep_count  = count_q;
    assign rep_sat    = sat_q;
    assign rep_err    = err_q;
    assign rep_abort  = abort_q;

endmodule

// File: rtl/z80fi_block_xfer_spec.sv
// Instruction spec for LDI/LDD/LDIR/LDDR: combinational decode and datapath plus the repeat tracker.
// Define Z80FI_BLOCK_FLAGS_EN to add the F register model (z80fi_reg_f_in / spec_reg_f_out).
module z80fi_block_xfer_spec
    import z80fi_block_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      z80fi_valid,
    input  logic [31:0]               z80fi_insn,
    input  logic [2:0]                z80fi_insn_len,
    input  logic [ADDR_W-1:0]         z80fi_reg_hl_in,
    input  logic [ADDR_W-1:0]         z80fi_reg_de_in,
    input  logic [ADDR_W-1:0]         z80fi_reg_bc_in,
    input  logic [ADDR_W-1:0]         z80fi_reg_ip_in,
    input  logic [7:0]                z80fi_bus_rdata,
`ifdef Z80FI_BLOCK_FLAGS_EN
    input  logic [7:0]                z80fi_reg_f_in,
    output logic [7:0]                spec_reg_f_out,
`endif
    output logic                      spec_valid,
    output logic [SPEC_SIGNALS_W-1:0] spec_signals,
    output logic [ADDR_W-1:0]         spec_bus_raddr,
    output logic [ADDR_W-1:0]         spec_bus_waddr,
    output logic [7:0]                spec_bus_wdata,
    output logic [ADDR_W-1:0]         spec_reg_hl_out,
    output logic [ADDR_W-1:0]         spec_reg_de_out,
    output logic [ADDR_W-1:0]         spec_reg_bc_out,
    output logic [ADDR_W-1:0]         spec_reg_ip_out,
    output logic                      rep_active,
    output logic [CNT_W-1:0]          rep_count,
    output logic                      rep_sat,
    output logic                      rep_err,
    output logic                      rep_abort
);

    logic [7:0] prefix, opcode;
    logic       is_dec, is_rep, bc_nz;
    logic       unused_insn_hi;

    assign prefix         = z80fi_insn[7:0];
    assign opcode         = z80fi_insn[15:8];
    assign unused_insn_hi = ^z80fi_insn[31:16];
    assign is_dec         = opcode[DIR_BIT];
    assign is_rep         = opcode[REP_BIT];

    assign spec_valid = z80fi_valid && (z80fi_insn_len == 3'd2) && (prefix == PREFIX_ED)
                        && is_block_op(opcode);

    assign spec_bus_raddr  = z80fi_reg_hl_in;
    assign spec_bus_waddr  = z80fi_reg_de_in;
    assign spec_bus_wdata  = z80fi_bus_rdata;
    assign spec_reg_hl_out = is_dec ? z80fi_reg_hl_in - ADDR_W'(1) : z80fi_reg_hl_in + ADDR_W'(1);
    assign spec_reg_de_out = is_dec ? z80fi_reg_de_in - ADDR_W'(1) : z80fi_reg_de_in + ADDR_W'(1);
    // BC=0 wraps to all-ones: a full 64 KiB transfer.
    assign spec_reg_bc_out = z80fi_reg_bc_in - ADDR_W'(1);
    assign bc_nz           = (spec_reg_bc_out != '0);
    assign spec_reg_ip_out = (is_rep && bc_nz) ? z80fi_reg_ip_in : z80fi_reg_ip_in + ADDR_W'(2);

    always_comb begin
        spec_signals             = '0;
        spec_signals[SIG_REG_IP] = 1'b1;
        spec_signals[SIG_REG_HL] = 1'b1;
        spec_signals[SIG_REG_DE] = 1'b1;
        spec_signals[SIG_REG_BC] = 1'b1;
        spec_signals[SIG_MEM_RD] = 1'b1;
        spec_signals[SIG_MEM_WR] = 1'b1;
`ifdef Z80FI_BLOCK_FLAGS_EN
        spec_signals[SIG_REG_F]  = 1'b1;
`endif
    end

`ifdef Z80FI_BLOCK_FLAGS_EN
    // S Z Y H X P/V N C
    assign spec_reg_f_out = {z80fi_reg_f_in[7:5], 1'b0, z80fi_reg_f_in[3], bc_nz, 1'b0, z80fi_reg_f_in[0]};
`endif

    z80fi_rep_tracker #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .z80fi_valid (z80fi_valid),
        .blk_valid   (spec_valid),
        .is_rep      (is_rep),
        .opcode      (opcode),
        .ip_in       (z80fi_reg_ip_in),
        .hl_in       (z80fi_reg_hl_in),
        .de_in       (z80fi_reg_de_in),
        .bc_in       (z80fi_reg_bc_in),
        .ip_out      (spec_reg_ip_out),
        .hl_out      (spec_reg_hl_out),
        .de_out      (spec_reg_de_out),
        .bc_out      (spec_reg_bc_out),
`ifdef Z80FI_BLOCK_FLAGS_EN
        .f_in        (z80fi_reg_f_in),
        .f_out       (spec_reg_f_out),
`endif
        .rep_active  (rep_active),
        .rep_count   (rep_count),
        .rep_sat     (rep_sat),
        .rep_err     (rep_err),
        .rep_abort   (rep_abort)
    );

endmodule

// File: tb/tb_z80fi_block_xfer_spec.sv
// Scoreboard bench for z80fi_block_xfer_spec: directed scenarios plus randomized chains vs. a chain-level model.
module tb_z80fi_block_xfer_spec;

    localparam int MAXI = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] hl_in, de_in, bc_in, ip_in;
    logic [7:0]  rdata;
    logic        spec_valid;
    logic [7:0]  spec_signals;
    logic [15:0] raddr, waddr, hl_out, de_out, bc_out, ip_out;
    logic [7:0]  wdata;
    logic        rep_active, rep_sat, rep_err, rep_abort;
    logic [7:0]  rep_count;

    always #5 clk = ~clk;

    z80fi_block_xfer_spec #(.ADDR_W(16), .CNT_W(8), .MAX_ITER(MAXI)) dut (
        .clk(clk), .reset_n(reset_n), .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn),
        .z80fi_insn_len(z80fi_insn_len), .z80fi_reg_hl_in(hl_in), .z80fi_reg_de_in(de_in),
        .z80fi_reg_bc_in(bc_in), .z80fi_reg_ip_in(ip_in), .z80fi_bus_rdata(rdata),
        .spec_valid(spec_valid), .spec_signals(spec_signals), .spec_bus_raddr(raddr),
        .spec_bus_waddr(waddr), .spec_bus_wdata(wdata), .spec_reg_hl_out(hl_out),
        .spec_reg_de_out(de_out), .spec_reg_bc_out(bc_out), .spec_reg_ip_out(ip_out),
        .rep_active(rep_active), .rep_count(rep_count), .rep_sat(rep_sat),
        .rep_err(rep_err), .rep_abort(rep_abort)
    );

    typedef struct {
        logic [15:0] raddr, waddr, hl, de, bc, ip;
        logic [7:0]  wdata;
    } comb_t;

    typedef struct {
        logic       active;
        logic [7:0] count;
        logic       sat, err, abort;
    } trk_t;

    comb_t comb_q[$];
    trk_t  trk_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Chain-level reference model
    bit          m_chain = 0;
    int          m_count = 0;
    bit          m_sat = 0;
    logic [7:0]  m_op;
    logic [15:0] m_ip, m_hl, m_de, m_bc;
    comb_t       last_c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_chain = 0; m_count = 0; m_sat = 0;
    endtask

    task automatic retire(input logic v, input logic [15:0] insn16, input logic [2:0] len,
                          input logic [15:0] hl, input logic [15:0] de, input logic [15:0] bc,
                          input logic [15:0] ip, input logic [7:0] rd);
        bit    blk, rep, dec;
        int    bco;
        comb_t c;
        trk_t  t;
        logic [7:0] op;
        @(negedge clk);
        z80fi_valid = v; z80fi_insn = {$urandom_range(0, 65535), insn16}; z80fi_insn_len = len;
        hl_in = hl; de_in = de; bc_in = bc; ip_in = ip; rdata = rd;
        op  = insn16[15:8];
        blk = v && len == 3'd2 && insn16[7:0] == 8'hED &&
              (op == 8'hA0 || op == 8'hA8 || op == 8'hB0 || op == 8'hB8);
        dec = (op == 8'hA8 || op == 8'hB8);
        rep = (op == 8'hB0 || op == 8'hB8);
        bco = (int'(bc) + 65535) % 65536;
        c.raddr = hl; c.waddr = de; c.wdata = rd;
        c.hl = 16'((int'(hl) + (dec ? 65535 : 1)) % 65536);
        c.de = 16'((int'(de) + (dec ? 65535 : 1)) % 65536);
        c.bc = 16'(bco);
        c.ip = (rep && bco != 0) ? ip : 16'((int'(ip) + 2) % 65536);
        last_c = c;
        if (blk) comb_q.push_back(c);
        t.err = 0; t.abort = 0;
        if (v) begin
            if (!m_chain) begin
                if (blk && rep && bco != 0) begin
                    m_chain = 1; m_count = 1; m_sat = 0;
                    m_op = op; m_ip = c.ip; m_hl = c.hl; m_de = c.de; m_bc = c.bc;
                end
            end else if (blk && op == m_op && ip == m_ip) begin
                if (hl == m_hl && de == m_de && bc == m_bc) begin
                    if (m_count < 255) m_count++;
                    if (m_count >= MAXI) m_sat = 1;
                    m_ip = c.ip; m_hl = c.hl; m_de = c.de; m_bc = c.bc;
                    if (bco == 0) begin m_chain = 0; m_count = 0; end
                end else begin
                    t.err = 1; m_chain = 0; m_count = 0;
                end
            end else begin
                t.abort = 1; m_chain = 0; m_count = 0;
            end
        end
        t.active = m_chain; t.count = 8'(m_count); t.sat = m_sat;
        trk_q.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            retire(1'b0, 16'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), 8'($urandom));
    endtask

    // Combinational monitor: one line per spec_valid retirement
    initial begin
        comb_t e;
        forever begin
            @(negedge clk); #2;
            if (spec_valid === 1'b1) begin
                if (comb_q.size() == 0) begin
                    chk("spurious_spec_valid", 32'(spec_valid), 32'd0);
                end else begin
                    e = comb_q.pop_front();
                    $display("retire hl=%h de=%h bc=%h ip=%h -> hl=%h de=%h bc=%h ip=%h",
                             hl_in, de_in, bc_in, ip_in, hl_out, de_out, bc_out, ip_out);
                    chk("raddr", 32'(raddr), 32'(e.raddr));
                    chk("waddr", 32'(waddr), 32'(e.waddr));
                    chk("wdata", 32'(wdata), 32'(e.wdata));
                    chk("hl_out", 32'(hl_out), 32'(e.hl));
                    chk("de_out", 32'(de_out), 32'(e.de));
                    chk("bc_out", 32'(bc_out), 32'(e.bc));
                    chk("ip_out", 32'(ip_out), 32'(e.ip));
                    chk("spec_signals", 32'(spec_signals), 32'h6F);
                end
            end
        end
    end

    // Tracker monitor: checks registered outputs after each stimulated edge
    initial begin
        trk_t e;
        forever begin
            @(posedge clk); #1;
            if (trk_q.size() > 0) begin
                e = trk_q.pop_front();
                chk("rep_active", 32'(rep_active), 32'(e.active));
                chk("rep_count", 32'(rep_count), 32'(e.count));
                chk("rep_sat", 32'(rep_sat), 32'(e.sat));
                chk("rep_err", 32'(rep_err), 32'(e.err));
                chk("rep_abort", 32'(rep_abort), 32'(e.abort));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] h, d, b, ip;
        logic [7:0]  op;
        int          r;
        bit          done;

        reset_n = 1'b0; z80fi_valid = 1'b0; z80fi_insn = '0; z80fi_insn_len = '0;
        hl_in = '0; de_in = '0; bc_in = '0; ip_in = '0; rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_active", 32'(rep_active), 32'd0);
        chk("reset_count", 32'(rep_count), 32'd0);
        chk("reset_sat", 32'(rep_sat), 32'd0);
        chk("reset_err", 32'(rep_err), 32'd0);
        chk("reset_abort", 32'(rep_abort), 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // LDI single shot
        retire(1, 16'hA0ED, 2, 16'h1000, 16'h2000, 16'h0003, 16'h0100, 8'h5A);
        chk("ldi_ip_model", 32'(last_c.ip), 32'h0102);
        idle(1);

        // LDDR, three consistent retirements
        retire(1, 16'hB8ED, 2, 16'h3000, 16'h4000, 16'h0003, 16'h0100, 8'h11);
        retire(1, 16'hB8ED, 2, 16'h2FFF, 16'h3FFF, 16'h0002, 16'h0100, 8'h22);
        retire(1, 16'hB8ED, 2, 16'h2FFE, 16'h3FFE, 16'h0001, 16'h0100, 8'h33);
        idle(1);

        // LDIR with BC=0 enters a 64K chain; a NOP at 0038 aborts it
        retire(1, 16'hB0ED, 2, 16'h8000, 16'h9000, 16'h0000, 16'h0200, 8'h44);
        retire(1, 16'h0000, 1, 16'h8001, 16'h9001, 16'hFFFF, 16'h0038, 8'h00);
        idle(2);

        // LDIR chain with HL off by one on the second retirement
        retire(1, 16'hB0ED, 2, 16'h1000, 16'h2000, 16'h0005, 16'h0300, 8'h55);
        retire(1, 16'hB0ED, 2, 16'h1002, 16'h2001, 16'h0004, 16'h0300, 8'h66);
        idle(2);

        // Saturation at MAX_ITER with BC=6; sat must outlive the chain
        h = 16'h0010; d = 16'h0020; b = 16'h0006;
        for (int i = 0; i < 6; i++) begin
            retire(1, 16'hB0ED, 2, h, d, b, 16'h0400, 8'(i));
            h = last_c.hl; d = last_c.de; b = last_c.bc;
        end
        idle(2);

        // Async reset mid-chain
        retire(1, 16'hB0ED, 2, 16'h5000, 16'h6000, 16'h0009, 16'h0500, 8'h77);
        @(negedge clk); z80fi_valid = 1'b0;
        #2; reset_n = 1'b0;
        #1;
        chk("async_rst_active", 32'(rep_active), 32'd0);
        chk("async_rst_count", 32'(rep_count), 32'd0);
        chk("async_rst_sat", 32'(rep_sat), 32'd0);
        chk("async_rst_err", 32'(rep_err), 32'd0);
        chk("async_rst_abort", 32'(rep_abort), 32'd0);
        model_reset();
        @(negedge clk); reset_n = 1'b1;

        // Randomized chains with occasional corruption, interruptions and idle gaps
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 3);
            op = (r == 0) ? 8'hA0 : (r == 1) ? 8'hA8 : (r == 2) ? 8'hB0 : 8'hB8;
            h = 16'($urandom); d = 16'($urandom); ip = 16'($urandom);
            b = 16'($urandom_range(1, 6));
            done = 0;
            for (int it = 0; it < 10 && !done; it++) begin
                r = $urandom_range(0, 19);
                if (r == 0 && it > 0) begin
                    r = $urandom_range(0, 2);
                    retire(1, {op, 8'hED}, 2, (r == 0) ? h + 16'd1 : h, (r == 1) ? d + 16'd1 : d,
                           (r == 2) ? b + 16'd1 : b, ip, 8'($urandom));
                    done = 1;
                end else if (r == 1 && it > 0) begin
                    retire(1, 16'($urandom), 1, h, d, b, 16'h0038, 8'($urandom));
                    done = 1;
                end else begin
                    if (r == 2) idle(1);
                    retire(1, {op, 8'hED}, 2, h, d, b, ip, 8'($urandom));
                    h = last_c.hl; d = last_c.de; b = last_c.bc;
                    done = !op[4] || (last_c.bc == 16'h0000);
                end
            end
            idle(1);
        end

        idle(2);
        @(negedge clk);
        chk("comb_queue_drained", 32'(comb_q.size()), 32'd0);
        chk("trk_queue_drained", 32'(trk_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
